// File: rtl/if_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package if_fetch_pkg;

    localparam int INST_W = 32;
    localparam int PC_W   = 32;

    localparam logic [PC_W-1:0]   DEFAULT_RESET_PC = 32'h0000_3000;
    localparam logic [INST_W-1:0] NOP              = '0;

    // One buffered fetch result: the instruction word and the PC it came from.
    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [PC_W-1:0]   pc;
    } fetch_entry_t;

    function automatic logic [PC_W-1:0] word_align(input logic [PC_W-1:0] addr);
        return addr & ~PC_W'(3);
    endfunction

endpackage

// File: rtl/if_fetch_if.sv
// Fetch-stage bus: instruction memory request/response, redirect, and decode handshake.
interface if_fetch_if;
    import if_fetch_pkg::*;

    logic              imem_en;
    logic [PC_W-1:0]   imem_addr;
    logic [INST_W-1:0] imem_rdata;
    logic              redirect;
    logic [PC_W-1:0]   redirect_pc;
    logic              inst_valid;
    logic [INST_W-1:0] inst;
    logic [PC_W-1:0]   inst_pc;
    logic              inst_ready;

    modport master (
        output imem_en, imem_addr, inst_valid, inst, inst_pc,
        input  imem_rdata, redirect, redirect_pc, inst_ready
    );

    modport slave (
        input  imem_en, imem_addr, inst_valid, inst, inst_pc,
        output imem_rdata, redirect, redirect_pc, inst_ready
    );

endinterface

// File: rtl/if_queue.sv
// Circular FIFO of {inst, pc} entries with push, pop and synchronous flush.
module if_queue
    import if_fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  fetch_entry_t           push_data,
    output fetch_entry_t           head_data,
    output logic                   head_valid,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fetch_entry_t    mem_reg [DEPTH];
    logic [AW-1:0]   head_ptr_reg;
    logic [AW-1:0]   tail_ptr_reg;
    logic [CW-1:0]   count_reg;
    logic            pop_eff;
    logic            push_eff;

    assign pop_eff  = pop & (count_reg != '0);
    assign push_eff = push & !flush;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= '{inst: NOP, pc: '0};
            end
        end else if (push_eff) begin
            mem_reg[tail_ptr_reg] <= push_data;
        end
    end

    // Flush wins over push/pop; stale storage contents are simply left behind.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head_ptr_reg <= '0;
            tail_ptr_reg <= '0;
            count_reg    <= '0;
        end else if (flush) begin
            head_ptr_reg <= '0;
            tail_ptr_reg <= '0;
            count_reg    <= '0;
        end else begin
            if (push_eff) begin
                tail_ptr_reg <= tail_ptr_reg + AW'(1);
            end
            if (pop_eff) begin
                head_ptr_reg <= head_ptr_reg + AW'(1);
            end
            if (push_eff && !pop_eff) begin
                count_reg <= count_reg + CW'(1);
            end else if (!push_eff && pop_eff) begin
                count_reg <= count_reg - CW'(1);
            end
        end
    end

    assign head_data  = mem_reg[head_ptr_reg];
    assign head_valid = (count_reg != '0);
    assign count      = count_reg;

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch: PC, credit-based imem requests, in-flight kill on redirect, fetch queue.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter int              DEPTH    = 2,
    parameter logic [PC_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clock,
    input  logic        reset,
    if_fetch_if.master  fif
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

    logic [PC_W-1:0] pc_reg;
    logic [PC_W-1:0] inflight_pc_reg;
    logic            inflight_reg;
    logic            kill_reg;

    logic            pop;
    logic            push;
    logic            req;
    logic [CW:0]     credit;
    logic [CW-1:0]   q_count;
    fetch_entry_t    head;
    logic            head_valid;

    assign pop = head_valid & fif.inst_ready;

    // Slots already spoken for: buffered entries plus the response still on its way.
    assign credit = {1'b0, q_count} + (CW+1)'(inflight_reg) - (CW+1)'(pop);
    assign req    = !reset & !fif.redirect & (credit < DEPTH_C);
    assign push   = inflight_reg & !kill_reg;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc_reg          <= RESET_PC;
            inflight_pc_reg <= '0;
            inflight_reg    <= 1'b0;
            kill_reg        <= 1'b0;
        end else begin
            kill_reg <= fif.redirect & inflight_reg;
            if (fif.redirect) begin
                pc_reg       <= word_align(fif.redirect_pc);
                inflight_reg <= 1'b0;
            end else begin
                inflight_reg <= req;
                if (req) begin
                    pc_reg          <= pc_reg + PC_W'(4);
                    inflight_pc_reg <= pc_reg;
                end
            end
        end
    end

    if_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clock      (clock),
        .reset      (reset),
        .push       (push),
        .pop        (pop),
        .flush      (fif.redirect),
        .push_data  ('{inst: fif.imem_rdata, pc: inflight_pc_reg}),
        .head_data  (head),
        .head_valid (head_valid),
        .count      (q_count)
    );

    assign fif.imem_en    = req;
    assign fif.imem_addr  = pc_reg;
    assign fif.inst_valid = head_valid;
    assign fif.inst       = head.inst;
    assign fif.inst_pc    = head.pc;

endmodule

// File: tb/tb_if_fetch.sv
// Randomized bench for if_fetch against a queue-based model of the fetch stream.
module tb_if_fetch;

    localparam int DEPTH = 2;
    localparam logic [31:0] RST_PC  = 32'h0000_3000;
    localparam logic [31:0] RST_PC2 = 32'hFFFF_FFF8;

    logic clock;
    logic reset;
    int   n_checks;
    int   n_errors;
    int   n_pops;

    if_fetch_if bus ();
    if_fetch_if bus2 ();

    if_fetch #(.DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
        .clock (clock),
        .reset (reset),
        .fif   (bus)
    );

    if_fetch #(.DEPTH(DEPTH), .RESET_PC(RST_PC2)) dut2 (
        .clock (clock),
        .reset (reset),
        .fif   (bus2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {2'b00, a[31:2]};
    endfunction

    // Synchronous-read instruction memories; garbage on idle cycles.
    always @(posedge clock) begin
        bus.imem_rdata  <= bus.imem_en  ? word_of(bus.imem_addr)  : $urandom;
        bus2.imem_rdata <= bus2.imem_en ? word_of(bus2.imem_addr) : $urandom;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Model: PCs buffered for decode, one possibly pending response, next fetch address.
    logic [31:0] mq [$];
    bit          pend;
    logic [31:0] pend_pc;
    logic [31:0] fetch_pc;

    task automatic model_reset();
        mq.delete();
        pend     = 1'b0;
        pend_pc  = '0;
        fetch_pc = RST_PC;
    endtask

    task automatic chk_reset_outputs();
        chk("rst_valid", 32'(bus.inst_valid), 32'd0);
        chk("rst_inst", bus.inst, 32'd0);
        chk("rst_inst_pc", bus.inst_pc, 32'd0);
        chk("rst_imem_en", 32'(bus.imem_en), 32'd0);
        chk("rst_imem_addr", bus.imem_addr, RST_PC);
        chk("rst2_imem_addr", bus2.imem_addr, RST_PC2);
    endtask

    task automatic cycle(input logic rdy, input logic rdr, input logic [31:0] rpc);
        logic exp_valid;
        logic exp_en;
        logic pop_m;
        int   occ;
        bus.inst_ready  = rdy;
        bus.redirect    = rdr;
        bus.redirect_pc = rpc;
        @(negedge clock);
        exp_valid = (mq.size() > 0);
        chk("inst_valid", 32'(bus.inst_valid), 32'(exp_valid));
        chk("q_count", 32'(dut.q_count), 32'(mq.size()));
        if (exp_valid) begin
            chk("inst_pc", bus.inst_pc, mq[0]);
            chk("inst", bus.inst, word_of(mq[0]));
        end
        pop_m  = exp_valid && rdy;
        occ    = mq.size() + (pend ? 1 : 0) - (pop_m ? 1 : 0);
        exp_en = !rdr && (occ < DEPTH);
        chk("imem_en", 32'(bus.imem_en), 32'(exp_en));
        if (exp_en) chk("imem_addr", bus.imem_addr, fetch_pc);
        if (pop_m) begin
            $display("pop pc=%08h inst=%08h", bus.inst_pc, bus.inst);
            void'(mq.pop_front());
            n_pops++;
        end
        if (rdr) begin
            mq.delete();
            pend     = 1'b0;
            fetch_pc = {rpc[31:2], 2'b00};
        end else begin
            if (pend) mq.push_back(pend_pc);
            pend    = exp_en;
            pend_pc = fetch_pc;
            if (exp_en) fetch_pc = fetch_pc + 32'd4;
        end
        @(posedge clock);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        n_pops   = 0;
        reset    = 1'b1;
        bus.inst_ready   = 1'b0;
        bus.redirect     = 1'b0;
        bus.redirect_pc  = '0;
        bus2.inst_ready  = 1'b1;
        bus2.redirect    = 1'b0;
        bus2.redirect_pc = '0;
        model_reset();
        repeat (3) @(posedge clock);
        #1;
        chk_reset_outputs();

        // Release: cycle 0 starts now; hold decode off to fill the queue.
        reset = 1'b0;
        cycle(1'b0, 1'b0, 32'd0);
        cycle(1'b0, 1'b0, 32'd0);
        chk("lat_valid", 32'(bus.inst_valid), 32'd1);
        chk("lat_pc", bus.inst_pc, RST_PC);
        chk("wrap_pc0", bus2.inst_pc, 32'hFFFF_FFF8);
        cycle(1'b0, 1'b0, 32'd0);
        chk("wrap_pc1", bus2.inst_pc, 32'hFFFF_FFFC);
        cycle(1'b0, 1'b0, 32'd0);
        chk("wrap_pc2", bus2.inst_pc, 32'h0000_0000);
        chk("wrap_inst2", bus2.inst, 32'h0000_0000);
        cycle(1'b0, 1'b0, 32'd0);
        cycle(1'b0, 1'b0, 32'd0);
        chk("bp_head", bus.inst_pc, RST_PC);
        chk("bp_stall", 32'(bus.imem_en), 32'd0);
        chk("bp_next_pc", bus.imem_addr, RST_PC + 32'd8);
        chk("bp_count", 32'(dut.q_count), 32'd2);

        n_pops = 0;
        repeat (30) cycle(1'b1, 1'b0, 32'd0);
        chk("throughput", n_pops, 32'd30);

        // Redirect with a response arriving this cycle.
        cycle(1'b0, 1'b1, 32'h0000_4002);
        cycle(1'b1, 1'b0, 32'd0);
        cycle(1'b1, 1'b0, 32'd0);
        chk("redir_valid", 32'(bus.inst_valid), 32'd1);
        chk("redir_pc", bus.inst_pc, 32'h0000_4000);
        repeat (4) cycle(1'b1, 1'b0, 32'd0);

        cycle(1'b1, 1'b1, 32'h0000_5000);
        cycle(1'b1, 1'b1, 32'h0000_6000);
        cycle(1'b1, 1'b0, 32'd0);
        cycle(1'b1, 1'b0, 32'd0);
        chk("redir2_pc", bus.inst_pc, 32'h0000_6000);

        repeat (300) begin
            cycle(($urandom_range(0, 9) < 7), ($urandom_range(0, 19) == 0), $urandom);
        end

        // Asynchronous reset with a half-full queue and a request in flight.
        repeat (4) cycle(1'b1, 1'b0, 32'd0);
        reset = 1'b1;
        #1;
        chk_reset_outputs();
        model_reset();
        @(posedge clock);
        #1;
        reset = 1'b0;
        cycle(1'b1, 1'b0, 32'd0);
        cycle(1'b1, 1'b0, 32'd0);
        chk("rst_restart_pc", bus.inst_pc, RST_PC);
        repeat (10) cycle(1'b1, 1'b0, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
